// File: rtl/cwm_c2p_if.sv
// CWM read port and PE weight stream bundled for cwm_c2p.
// master = the converter, slave = the CWM/PE side.
`ifndef CWM_DEPTH
`define CWM_DEPTH 1024
`endif
`ifndef M
`define M 4
`endif

interface cwm_c2p_if #(
  parameter int unsigned ADDR_W = $clog2(`CWM_DEPTH),
  parameter int unsigned DATA_W = `M*4*8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] pe_tdata;
  logic              pe_tvalid;
  logic              pe_tready;
  logic              pe_tlast;

  modport master (
    output rd_en, rd_addr, pe_tdata, pe_tvalid, pe_tlast,
    input  dout, pe_tready
  );

  modport slave (
    input  rd_en, rd_addr, pe_tdata, pe_tvalid, pe_tlast,
    output dout, pe_tready
  );
endinterface

// File: rtl/cwm_c2p.sv
// CWM-to-PE converter: reads a run of CWM words behind the writer's fill pointer
// and streams them to the PE array through a credit-protected output FIFO.
`ifndef CWM_DEPTH
`define CWM_DEPTH 1024
`endif
`ifndef M
`define M 4
`endif

module cwm_c2p #(
  parameter int unsigned ADDR_W     = $clog2(`CWM_DEPTH),
  parameter int unsigned DATA_W     = `M*4*8,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_pulse,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       n_words,
  input  logic [ADDR_W:0]   wr_ptr,
  cwm_c2p_if.master         bus,
  output logic              busy,
  output logic              done_pulse
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = FA_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_nxt;
  logic [31:0]       r_remaining, w_remaining_nxt;
  logic              r_wrapped, w_wrapped_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic              r_rd_last, w_rd_last_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [RD_LAT-1:0] r_vld_sr, w_vld_sr_nxt;
  logic [RD_LAT-1:0] r_last_sr, w_last_sr_nxt;
  logic [CNT_W-1:0]  r_inflight, w_inflight_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [FA_W-1:0]   r_wa, w_wa_nxt;
  logic [FA_W-1:0]   r_ra, w_ra_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [DATA_W-1:0] r_pe_tdata, w_pe_tdata_nxt;
  logic              r_pe_tvalid, w_pe_tvalid_nxt;
  logic              r_pe_tlast, w_pe_tlast_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_accept;
  logic              w_go;
  logic              w_active;
  logic [PTR_W-1:0]  w_cur_ptr;
  logic [31:0]       w_cur_rem;
  logic              w_cur_wrapped;
  logic              w_credit;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_push;
  logic              w_push_last;
  logic              w_pop;
  logic              w_last_hs;
  logic [DATA_W-1:0] w_head;
  logic              w_head_last;

  // Next-state and next-output logic for the whole converter.
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_remaining_nxt = r_remaining;
    w_wrapped_nxt   = r_wrapped;
    w_rd_addr_nxt   = r_rd_addr;
    w_head          = r_mem[r_ra];
    w_head_last     = r_mem_last[r_ra];

    // The first read is issued from the start cycle itself, straight off c_addr.
    w_accept      = (r_state == IDLE) && start_pulse;
    w_go          = w_accept && (n_words != 32'd0);
    w_active      = w_go || (r_state == RUN);
    w_cur_ptr     = (r_state == IDLE) ? {1'b0, c_addr} : r_rd_ptr;
    w_cur_rem     = (r_state == IDLE) ? n_words : r_remaining;
    w_cur_wrapped = (r_state == IDLE) ? 1'b0 : r_wrapped;

    // Reads still in the CWM pipe are counted as FIFO occupancy, so pushes never overflow.
    w_credit     = (SUM_W'(r_inflight) + SUM_W'(r_count)) < SUM_W'(FIFO_DEPTH);
    w_issue      = w_active && (w_cur_rem != 32'd0) && !w_cur_wrapped &&
                   (w_cur_ptr < wr_ptr) && w_credit;
    w_issue_last = w_issue && (w_cur_rem == 32'd1);

    w_push      = r_vld_sr[RD_LAT-1];
    w_push_last = r_last_sr[RD_LAT-1];
    w_pop       = r_pe_tvalid && bus.pe_tready;
    w_last_hs   = w_pop && r_pe_tlast;

    if (w_go) begin
      w_rd_ptr_nxt    = {1'b0, c_addr};
      w_remaining_nxt = n_words;
      w_wrapped_nxt   = 1'b0;
    end
    if (w_issue) begin
      w_rd_ptr_nxt    = w_cur_ptr + PTR_W'(1);
      w_remaining_nxt = w_cur_rem - 32'd1;
      w_wrapped_nxt   = (w_cur_ptr == {PTR_W{1'b1}});
      w_rd_addr_nxt   = w_cur_ptr[ADDR_W-1:0];
    end
    w_rd_en_nxt   = w_issue;
    w_rd_last_nxt = w_issue_last;

    unique case (r_state)
      IDLE:    if (w_go) w_state_nxt = w_issue_last ? DRAIN : RUN;
      RUN:     if (w_issue_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_vld_sr_nxt[0]  = r_rd_en;
    w_last_sr_nxt[0] = r_rd_en && r_rd_last;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      w_vld_sr_nxt[i]  = r_vld_sr[i-1];
      w_last_sr_nxt[i] = r_last_sr[i-1];
    end

    w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
    w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_wa_nxt       = w_push ? r_wa + FA_W'(1) : r_wa;
    w_ra_nxt       = w_pop ? r_ra + FA_W'(1) : r_ra;

    // Registered FIFO head: bypass the pushed word when it becomes the new head.
    if (w_push && ((r_count == CNT_W'(0)) || ((r_count == CNT_W'(1)) && w_pop))) begin
      w_head      = bus.dout;
      w_head_last = w_push_last;
    end else begin
      w_head      = r_mem[w_ra_nxt];
      w_head_last = r_mem_last[w_ra_nxt];
    end
    w_pe_tvalid_nxt = (w_count_nxt != CNT_W'(0));
    w_pe_tdata_nxt  = w_pe_tvalid_nxt ? w_head : r_pe_tdata;
    w_pe_tlast_nxt  = w_pe_tvalid_nxt && w_head_last;

    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_accept && (n_words == 32'd0)) || w_last_hs;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_wrapped   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_addr   <= '0;
      r_vld_sr    <= '0;
      r_last_sr   <= '0;
      r_inflight  <= '0;
      r_count     <= '0;
      r_wa        <= '0;
      r_ra        <= '0;
      r_pe_tdata  <= '0;
      r_pe_tvalid <= 1'b0;
      r_pe_tlast  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_wrapped   <= w_wrapped_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_last   <= w_rd_last_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_vld_sr    <= w_vld_sr_nxt;
      r_last_sr   <= w_last_sr_nxt;
      r_inflight  <= w_inflight_nxt;
      r_count     <= w_count_nxt;
      r_wa        <= w_wa_nxt;
      r_ra        <= w_ra_nxt;
      r_pe_tdata  <= w_pe_tdata_nxt;
      r_pe_tvalid <= w_pe_tvalid_nxt;
      r_pe_tlast  <= w_pe_tlast_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // FIFO storage; occupancy lives in the pointers, so contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wa]      <= bus.dout;
      r_mem_last[r_wa] <= w_push_last;
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.pe_tdata  = r_pe_tdata;
  assign bus.pe_tvalid = r_pe_tvalid;
  assign bus.pe_tlast  = r_pe_tlast;
  assign busy          = r_busy;
  assign done_pulse    = r_done;

endmodule

// File: tb/tb_cwm_c2p.sv
// Directed bench for cwm_c2p: CWM read-latency model, stream monitor, vector table
// plus hand-written sequences for back-pressure, pointer gating, restart and reset.
module tb_cwm_c2p;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start_pulse = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [31:0]       n_words = '0;
  logic [ADDR_W:0]   wr_ptr = '0;
  logic              pe_tready = 1'b1;
  logic              busy;
  logic              done_pulse;

  cwm_c2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cwm_c2p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start_pulse(start_pulse), .c_addr(c_addr),
    .n_words(n_words), .wr_ptr(wr_ptr), .bus(bus), .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // CWM model: data appears RD_LAT cycles after rd_en, garbage otherwise.
  logic [DATA_W-1:0] r_pipe [RD_LAT];
  always @(posedge clk) begin
    r_pipe[0] <= bus.rd_en ? word_of(bus.rd_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(RD_LAT); i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign bus.dout      = r_pipe[RD_LAT-1];
  assign bus.pe_tready = pe_tready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc, first_vld_cyc, last_beat_cyc, done_cyc, done_cnt, hold_err, viol_cnt;
  bit busy_seen, prev_stall;
  logic [DATA_W:0]   prev_out;
  logic [ADDR_W-1:0] rd_q[$];
  int                rd_cyc_q[$];
  logic [DATA_W:0]   beat_q[$];

  always @(negedge clk) begin
    if (start_pulse && start_cyc < 0) start_cyc = cyc;
    if (busy) busy_seen = 1'b1;
    if (bus.rd_en) begin
      rd_q.push_back(bus.rd_addr);
      rd_cyc_q.push_back(cyc);
      if ({1'b0, bus.rd_addr} >= wr_ptr) viol_cnt++;
    end
    if (bus.pe_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (prev_stall && (!bus.pe_tvalid || {bus.pe_tlast, bus.pe_tdata} !== prev_out)) hold_err++;
    prev_stall = bus.pe_tvalid && !pe_tready;
    prev_out   = {bus.pe_tlast, bus.pe_tdata};
    if (bus.pe_tvalid && pe_tready) begin
      beat_q.push_back({bus.pe_tlast, bus.pe_tdata});
      if (bus.pe_tlast) last_beat_cyc = cyc;
    end
    if (done_pulse) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_mon();
    start_cyc = -1; first_vld_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    done_cnt = 0; hold_err = 0; viol_cnt = 0; busy_seen = 1'b0; prev_stall = 1'b0;
    rd_q.delete(); rd_cyc_q.delete(); beat_q.delete();
  endtask

  task automatic start_xfer(input int a, input int n);
    @(posedge clk); #1;
    c_addr = ADDR_W'(a); n_words = 32'(n); start_pulse = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({nm, "_done_seen"}, longint'(done_cnt != 0), 1);
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check_rd(input string nm, input int base, input int n, input bit contig);
    int err = 0;
    chk({nm, "_rd_cnt"}, longint'(rd_q.size()), longint'(n));
    for (int i = 0; i < rd_q.size() && i < n; i++) begin
      if (rd_q[i] !== ADDR_W'(base + i)) err++;
      if (contig && (rd_cyc_q[i] - rd_cyc_q[0] != i)) err++;
    end
    chk({nm, "_rd_seq"}, longint'(err), 0);
  endtask

  task automatic check_beats(input string nm, input int base, input int n);
    int err = 0;
    chk({nm, "_beat_cnt"}, longint'(beat_q.size()), longint'(n));
    for (int i = 0; i < beat_q.size() && i < n; i++) begin
      if (beat_q[i][DATA_W-1:0] !== word_of(ADDR_W'(base + i))) err++;
      if (beat_q[i][DATA_W] !== (i == n - 1)) err++;
    end
    chk({nm, "_beat_seq"}, longint'(err), 0);
  endtask

  typedef struct {
    int              c_addr;
    int              n;
    logic [ADDR_W:0] wp;
    int              exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16,   4,  11'd100,  4};
    vecs[1] = '{0,    1,  11'd1,    4};
    vecs[2] = '{40,   12, 11'd200,  4};
    vecs[3] = '{1020, 4,  11'd1024, 4};
    vecs[4] = '{5,    8,  11'd13,   4};

    reset_mon();
    settle(3);
    chk("reset_ctrl", longint'({bus.rd_en, bus.pe_tvalid, bus.pe_tlast, busy, done_pulse}), 0);
    chk("reset_tdata", longint'(bus.pe_tdata), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    settle(2);

    // Uninterrupted transfers with the writer well ahead and the PE always ready.
    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      reset_mon();
      wr_ptr = vecs[v].wp;
      pe_tready = 1'b1;
      start_xfer(vecs[v].c_addr, vecs[v].n);
      wait_done(nm, 200);
      settle(3);
      chk({nm, "_latency"}, longint'(first_vld_cyc - start_cyc), longint'(vecs[v].exp_lat));
      check_rd(nm, vecs[v].c_addr, vecs[v].n, 1'b1);
      check_beats(nm, vecs[v].c_addr, vecs[v].n);
      chk({nm, "_done_gap"}, longint'(done_cyc - last_beat_cyc), 1);
      chk({nm, "_done_cnt"}, longint'(done_cnt), 1);
      chk({nm, "_busy_end"}, longint'(busy), 0);
    end

    // Writer trickles in one word every 3 cycles.
    reset_mon();
    wr_ptr = '0;
    start_xfer(0, 8);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat (3) @(posedge clk);
          #1 wr_ptr = wr_ptr + 11'd1;
        end
      end
      wait_done("trickle", 300);
    join
    settle(3);
    chk("trickle_ptr_viol", longint'(viol_cnt), 0);
    check_rd("trickle", 0, 8, 1'b0);
    check_beats("trickle", 0, 8);

    // Long back-pressure: only FIFO_DEPTH reads may be outstanding, head must hold.
    reset_mon();
    wr_ptr = 11'd500;
    pe_tready = 1'b0;
    start_xfer(100, 20);
    settle(30);
    chk("bp_rd_bound", longint'(rd_q.size() <= int'(FIFO_DEPTH)), 1);
    chk("bp_rd_filled", longint'(rd_q.size()), longint'(FIFO_DEPTH));
    chk("bp_no_beats", longint'(beat_q.size()), 0);
    chk("bp_head", longint'({bus.pe_tvalid, bus.pe_tlast, bus.pe_tdata}),
        longint'({1'b1, 1'b0, word_of(10'd100)}));
    @(posedge clk); #1;
    pe_tready = 1'b1;
    wait_done("bp", 300);
    settle(3);
    check_beats("bp", 100, 20);
    chk("bp_hold", longint'(hold_err), 0);
    chk("bp_done_cnt", longint'(done_cnt), 1);

    // Zero-length request completes without reads or busy.
    reset_mon();
    wr_ptr = 11'd100;
    start_xfer(7, 0);
    wait_done("zero", 20);
    settle(3);
    chk("zero_done_gap", longint'(done_cyc - start_cyc), 1);
    chk("zero_rd_cnt", longint'(rd_q.size()), 0);
    chk("zero_busy", longint'(busy_seen), 0);
    chk("zero_done_cnt", longint'(done_cnt), 1);

    // A second start while busy must be ignored.
    reset_mon();
    wr_ptr = 11'd400;
    start_xfer(16, 6);
    start_xfer(300, 3);
    wait_done("restart", 200);
    settle(5);
    check_rd("restart", 16, 6, 1'b1);
    check_beats("restart", 16, 6);
    chk("restart_done_cnt", longint'(done_cnt), 1);

    // Reset in the middle of a transfer, then a clean short transfer.
    reset_mon();
    wr_ptr = 11'd500;
    start_xfer(50, 10);
    begin
      int k = 0;
      int err = 0;
      while (beat_q.size() < 5 && k < 100) begin
        @(negedge clk); #1;
        k++;
      end
      chk("rst_mid_beats", longint'(beat_q.size()), 5);
      for (int i = 0; i < beat_q.size(); i++)
        if (beat_q[i] !== {1'b0, word_of(ADDR_W'(50 + i))}) err++;
      chk("rst_mid_data", longint'(err), 0);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_mid_ctrl", longint'({bus.rd_en, bus.pe_tvalid, bus.pe_tlast, busy, done_pulse}), 0);
    chk("rst_mid_tdata", longint'(bus.pe_tdata), 0);
    chk("rst_mid_rdaddr", longint'(bus.rd_addr), 0);
    #1;
    rstn = 1'b1;
    reset_mon();
    settle(6);
    chk("rst_post_beats", longint'(beat_q.size()), 0);
    chk("rst_post_valid", longint'(bus.pe_tvalid), 0);
    start_xfer(32, 2);
    wait_done("rst_new", 100);
    settle(4);
    check_rd("rst_new", 32, 2, 1'b1);
    check_beats("rst_new", 32, 2);
    chk("rst_new_done_cnt", longint'(done_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
